// File: rtl/fsm_alimentador_piezas.sv
// rtl/fsm_alimentador_piezas.sv - piece feeder FSM driving an inspection handshake
//
// Feeds a batch of pieces to an inspection FSM. Each piece is presented (P),
// its expected quality is shown on RI, and the FSM waits for an accept or
// reject acknowledge on Y. The acknowledge totals are counted and saturate
// at 15. A fault response, or no response within TIMEOUT cycles, aborts the
// batch with a sticky error flag.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - batch request, sampled only in IDLE
//   batch_len  - pieces in the batch (0 = empty batch, done pulse only)
//   pattern    - expected quality per piece, bit idx: 1 = reject, 0 = accept
//   Y          - response: 00 none, 01 accept-ack, 10 reject-ack, 11 fault
//   P          - piece present
//   RI         - inspection result for the piece in flight
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse at batch end (normal or aborted)
//   error      - sticky, cleared by reset or an accepted start
//   ok_count   - acknowledged accepts
//   rej_count  - acknowledged rejects
//
// Optional feature: define ALIMENTADOR_CHECK_EN to abort the batch when the
// acknowledge disagrees with RI.

module fsm_alimentador_piezas #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] batch_len,
    input  logic [7:0] pattern,
    input  logic [1:0] Y,
    output logic       P,
    output logic       RI,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] ok_count,
    output logic [3:0] rej_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        INSPECT,
        WAIT_ACK,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] pattern_q, pattern_d;
    logic [7:0] timer_q, timer_d;
    logic       p_q, p_d;
    logic       ri_q, ri_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [3:0] ok_q, ok_d;
    logic [3:0] rej_q, rej_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        pattern_d   = pattern_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        error_d     = error_q;
        ok_d        = ok_q;
        rej_d       = rej_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ok_d    = 4'd0;
                    rej_d   = 4'd0;
                    error_d = 1'b0;
                    if (batch_len != 4'd0) begin
                        state_d     = PRESENT;
                        remaining_d = batch_len;
                        idx_d       = 3'd0;
                        pattern_d   = pattern;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PRESENT: state_d = INSPECT;
            INSPECT: begin
                state_d = WAIT_ACK;
                timer_d = 8'd0;
            end
            WAIT_ACK: begin
                case (Y)
                    2'b01: begin
`ifdef ALIMENTADOR_CHECK_EN
                        if (ri_q) begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ok_d    = (ok_q == 4'hF) ? ok_q : ok_q + 4'd1;
                            state_d = GAP;
                        end
`else
                        ok_d    = (ok_q == 4'hF) ? ok_q : ok_q + 4'd1;
                        state_d = GAP;
`endif
                    end
                    2'b10: begin
`ifdef ALIMENTADOR_CHECK_EN
                        if (!ri_q) begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            rej_d   = (rej_q == 4'hF) ? rej_q : rej_q + 4'd1;
                            state_d = GAP;
                        end
`else
                        rej_d   = (rej_q == 4'hF) ? rej_q : rej_q + 4'd1;
                        state_d = GAP;
`endif
                    end
                    2'b11: begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: begin
                        // A response on the last allowed cycle still wins;
                        // only a silent cycle can expire the timer.
                        if (timer_q + 8'd1 == TIMEOUT_C) begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            timer_d = timer_q + 8'd1;
                        end
                    end
                endcase
            end
            GAP: begin
                remaining_d = remaining_q - 4'd1;
                if (remaining_d == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // 3-bit index wraps so pieces beyond 8 reuse the pattern
                    idx_d   = idx_q + 3'd1;
                    state_d = PRESENT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        p_d  = (state_d == PRESENT) || (state_d == INSPECT) || (state_d == WAIT_ACK);
        ri_d = ((state_d == INSPECT) || (state_d == WAIT_ACK)) ? pattern_d[idx_d] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= 4'd0;
            idx_q       <= 3'd0;
            pattern_q   <= 8'd0;
            timer_q     <= 8'd0;
            p_q         <= 1'b0;
            ri_q        <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ok_q        <= 4'd0;
            rej_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            pattern_q   <= pattern_d;
            timer_q     <= timer_d;
            p_q         <= p_d;
            ri_q        <= ri_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ok_q        <= ok_d;
            rej_q       <= rej_d;
        end
    end

    assign P         = p_q;
    assign RI        = ri_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign ok_count  = ok_q;
    assign rej_count = rej_q;

endmodule

// File: tb/tb_fsm_alimentador_piezas.sv
// tb/tb_fsm_alimentador_piezas.sv - self-checking bench for fsm_alimentador_piezas
module tb_fsm_alimentador_piezas;

    localparam int TIMEOUT = 15;
`ifdef ALIMENTADOR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] batch_len;
    logic [7:0] pattern;
    logic [1:0] Y;
    logic       P, RI, busy, done, error;
    logic [3:0] ok_count, rej_count;

    always #5 clk = ~clk;

    fsm_alimentador_piezas #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .batch_len(batch_len),
        .pattern(pattern), .Y(Y), .P(P), .RI(RI), .busy(busy), .done(done),
        .error(error), .ok_count(ok_count), .rej_count(rej_count)
    );

    int tests = 0;
    int fails = 0;
    int last_busy;

    // per-piece response plan: del_a idle cycles, then rsp_a
    int         del_a [16];
    logic [1:0] rsp_a [16];

    // per-busy-cycle expectation {P,RI,busy,done,error} and Y to drive
    logic [4:0] sv [$];
    logic [1:0] sy [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            del_a[i] = 0;
            rsp_a[i] = 2'b01;
        end
    endtask

    // Outcome model: walk the pieces and lay out the cycle timeline directly.
    task automatic run_batch(input logic [3:0] len, input logic [7:0] pat,
                             input bit stray, input string tag);
        int   c_ok = 0;
        int   c_rej = 0;
        bit   err = 1'b0;
        bit   ri, to, bad;
        int   w;
        int   busy_seen = 0;
        sv.delete();
        sy.delete();
        for (int i = 0; i < int'(len); i++) begin
            ri = pat[i % 8];
            sv.push_back(5'b10100);            sy.push_back(2'($urandom));
            sv.push_back({1'b1, ri, 3'b100});  sy.push_back(2'($urandom));
            to = (del_a[i] >= TIMEOUT);
            w  = to ? TIMEOUT : del_a[i] + 1;
            for (int j = 0; j < w; j++) begin
                sv.push_back({1'b1, ri, 3'b100});
                sy.push_back((j == w - 1 && !to) ? rsp_a[i] : 2'b00);
            end
            bad = CHECK_EN && ((rsp_a[i] == 2'b01 && ri) || (rsp_a[i] == 2'b10 && !ri));
            if (to || rsp_a[i] == 2'b11 || bad) begin
                err = 1'b1;
                break;
            end
            if (rsp_a[i] == 2'b01) c_ok = (c_ok < 15) ? c_ok + 1 : 15;
            else                   c_rej = (c_rej < 15) ? c_rej + 1 : 15;
            sv.push_back(5'b00100);            sy.push_back(2'($urandom));
        end

        start = 1'b1; batch_len = len; pattern = pat; Y = 2'($urandom);
        for (int c = 0; c < sv.size(); c++) begin
            step();
            check($sformatf("%s cyc%0d", tag, c + 1), {27'd0, P, RI, busy, done, error}, {27'd0, sv[c]});
            busy_seen += int'(busy);
            Y         = sy[c];
            start     = stray && ($urandom_range(3) == 0);
            batch_len = 4'($urandom);
            pattern   = 8'($urandom);
        end
        step();
        start = 1'b0; Y = 2'($urandom);
        check({tag, " end"}, {27'd0, P, RI, busy, done, error}, {27'd0, 4'b0001, err});
        check({tag, " counts"}, {24'd0, ok_count, rej_count}, {24'd0, 4'(c_ok), 4'(c_rej)});
        check({tag, " busy cycles"}, busy_seen, sv.size());
        step();
        check({tag, " idle"}, {23'd0, P, RI, busy, done, error, ok_count, rej_count},
              {23'd0, 4'b0000, err, 4'(c_ok), 4'(c_rej)});
        last_busy = busy_seen;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; batch_len = 4'd0; pattern = 8'd0; Y = 2'b00;
        #1 reset = 1'b1;
        #1;
        check("reset state", {19'd0, P, RI, busy, done, error, ok_count, rej_count}, 32'd0);
        step();
        step();
        reset = 1'b0;

        // three pieces, correct acks, minimum period
        clear_plan();
        rsp_a[0] = 2'b01; rsp_a[1] = 2'b10; rsp_a[2] = 2'b01;
        run_batch(4'd3, 8'b0000_0010, 1'b0, "basic");
        check("basic 12 busy", last_busy, 12);

        // no response: abort after TIMEOUT wait cycles
        clear_plan();
        del_a[0] = 40;
        run_batch(4'd1, 8'h00, 1'b0, "timeout");
        check("timeout busy", last_busy, 2 + TIMEOUT);

        // fault on piece 2 of 4
        clear_plan();
        rsp_a[0] = 2'b01; rsp_a[1] = 2'b11; del_a[1] = 2;
        run_batch(4'd4, 8'b0000_0010, 1'b0, "fault");

        // empty batch
        clear_plan();
        run_batch(4'd0, 8'hFF, 1'b0, "empty");

        // reset mid WAIT_ACK with an ignored start while busy
        start = 1'b1; batch_len = 4'd3; pattern = 8'h00; Y = 2'b00;
        step();                                   // PRESENT
        start = 1'b0;
        step();                                   // INSPECT
        step();                                   // WAIT_ACK piece 1
        Y = 2'b01;
        step();                                   // GAP
        Y = 2'b00; start = 1'b1; batch_len = 4'd0;
        step();                                   // PRESENT piece 2
        start = 1'b0;
        step();                                   // INSPECT
        step();                                   // WAIT_ACK piece 2
        check("pre-reset", {22'd0, P, RI, busy, done, error, ok_count, rej_count},
              {22'd0, 5'b10100, 4'd1, 4'd0});
        #2 reset = 1'b1;
        #1;
        check("async reset", {19'd0, P, RI, busy, done, error, ok_count, rej_count}, 32'd0);
        step();
        reset = 1'b0;

        // acknowledge disagreeing with RI
        clear_plan();
        rsp_a[0] = 2'b01;
        run_batch(4'd1, 8'h01, 1'b0, "mismatch");
        check("mismatch result", {27'd0, error, ok_count},
              CHECK_EN ? {27'd0, 1'b1, 4'd0} : {27'd0, 1'b0, 4'd1});

        // random batches
        for (int b = 0; b < 30; b++) begin
            logic [3:0] len;
            logic [7:0] pat;
            int         r;
            len = 4'($urandom);
            pat = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(9);
                del_a[i] = (r == 0) ? TIMEOUT - 1 + $urandom_range(2) : $urandom_range(2);
                r = $urandom_range(19);
                if (r < 16)      rsp_a[i] = pat[i % 8] ? 2'b10 : 2'b01;
                else if (r < 19) rsp_a[i] = pat[i % 8] ? 2'b01 : 2'b10;
                else             rsp_a[i] = 2'b11;
            end
            run_batch(len, pat, 1'b1, $sformatf("rnd%0d", b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fsm_alimentador_piezas.md
FSM_ALIMENTADOR_PIEZAS -- requirements
Module: fsm_alimentador_piezas

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the WAIT_ACK cycles allowed before abort (range 1-255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a batch request sampled only in IDLE.
REQ-005 SHALL have port batch_len, input, 4, the number of pieces in the batch, sampled with start.
REQ-006 SHALL have port pattern, input, 8, the expected quality per piece (bit idx: 1=reject, 0=accept), sampled with start.
REQ-007 SHALL have port Y, input, 2, the protocol response: 00 none, 01 accept-ack, 10 reject-ack, 11 fault.
REQ-008 SHALL have port P, output, 1, piece present to the inspection FSM.
REQ-009 SHALL have port RI, output, 1, inspection result to the inspection FSM.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse at batch end (normal or aborted).
REQ-012 SHALL have port error, output, 1, sticky; cleared only by reset or an accepted start.
REQ-013 SHALL have ports ok_count and rej_count, output, 4 each, the acknowledged accept and reject totals.

Function
REQ-014 SHALL implement states IDLE, PRESENT, INSPECT, WAIT_ACK, GAP; all outputs registered or decoded from registered state only.
REQ-015 IDLE: start=1 with batch_len!=0 -> PRESENT; load remaining=batch_len, idx=0, latch pattern, clear counts and error.
REQ-016 IDLE: start=1 with batch_len=0 -> pulse done the next cycle, stay IDLE, clear counts and error.
REQ-017 PRESENT: P=1, RI=0, one cycle, then INSPECT.
REQ-018 INSPECT: P=1, RI=pattern[idx], one cycle, then WAIT_ACK with timer=0.
REQ-019 WAIT_ACK: P=1 and RI held; Y=01 -> ok_count+1 and GAP; Y=10 -> rej_count+1 and GAP.
REQ-020 WAIT_ACK: Y=11 -> error=1, done pulse, IDLE.
REQ-021 WAIT_ACK: Y=00 -> timer+1; on the cycle timer reaches TIMEOUT -> error=1, done pulse, IDLE.
REQ-022 GAP: P=0, RI=0, one cycle; remaining-1; if the result is 0 -> done pulse and IDLE, else idx=(idx+1) mod 8 and PRESENT.
REQ-023 Counters SHALL saturate at 15; pieces beyond 8 SHALL reuse pattern bits cyclically.
REQ-024 start while busy SHALL be ignored with no effect on state, counts or latched inputs.
REQ-025 P SHALL rise exactly one cycle after start is sampled; the minimum per-piece period is 4 cycles (Y=01/10 on the first WAIT_ACK cycle).

Reset
REQ-026 Asserting reset at any time, including mid-batch, SHALL force IDLE and P=RI=busy=done=error=0 and ok_count=rej_count=0 asynchronously.
REQ-027 After reset release, the first active edge SHALL evaluate IDLE transitions normally.

Configuration
REQ-028 Macro ALIMENTADOR_CHECK_EN SHALL, when defined, treat Y=01 with RI=1 or Y=10 with RI=0 in WAIT_ACK as a mismatch: error=1, done pulse, IDLE, count unchanged.
REQ-029 Without ALIMENTADOR_CHECK_EN, any Y=01/10 SHALL be accepted per REQ-019 regardless of RI.

Verification
REQ-030 The bench SHALL cover: reset, then start with batch_len=3, pattern=8'b010 and correct Y=01/10/01 -> ok_count=2, rej_count=1, done 1 cycle, error=0, 12 busy cycles.
REQ-031 The bench SHALL cover: batch_len=1 with Y held 00 and TIMEOUT=15 -> error=1 and done after 15 WAIT_ACK cycles, P=0 next cycle.
REQ-032 The bench SHALL cover: Y=11 in WAIT_ACK of piece 2 of 4 -> error=1, ok_count=1, IDLE next cycle.
REQ-033 The bench SHALL cover: start=1 with batch_len=0 -> done pulse, busy stays 0, P never rises.
REQ-034 The bench SHALL cover: reset asserted mid-WAIT_ACK -> all outputs 0 immediately, with no clock edge; a start pulse during busy is ignored.
REQ-035 The bench SHALL cover, with ALIMENTADOR_CHECK_EN: pattern bit 1 answered with Y=01 -> error=1, ok_count=0; without the macro -> ok_count=1, error=0.
